// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: data widths, fetch FSM states and
// the fetch buffer entry layout.
package riscv_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous fetch buffer with flush. Flush wins over push/pop;
// storage is cleared on reset so the head reads as zero afterwards.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            push,
  input  logic [XLEN-1:0] push_pc,
  input  logic [ILEN-1:0] push_instr,
  input  logic            pop,
  output logic [2:0]      count,
  output logic [XLEN-1:0] head_pc,
  output logic [ILEN-1:0] head_instr
);

  localparam int unsigned PW = $clog2(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;
  logic [PW-1:0]   rd_next;
  logic [PW-1:0]   wr_next;

  // Guard against push when full and pop when empty; pointers wrap at DEPTH.
  always_comb begin
    do_push = push && (count < 3'(DEPTH));
    do_pop  = pop && (count != '0);
    rd_next = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
    wr_next = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= '{pc: push_pc, instr: push_instr};
        wr_ptr      <= wr_next;
      end
      if (do_pop) rd_ptr <= rd_next;
      count <= count + 3'(do_push) - 3'(do_pop);
    end
  end

  assign head_pc    = mem[rd_ptr].pc;
  assign head_instr = mem[rd_ptr].instr;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: sequential fetch with one outstanding memory
// request, branch redirect/flush and a small decode-side buffer.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 64'h0,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr
);

  fetch_state_t    state;
  logic [XLEN-1:0] fetch_pc;
  logic [2:0]      fifo_count;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] redirect_target;
  logic            unused_redirect_lsbs;

  // Request, push/pop and output-valid glue; redirect suppresses all of them.
  always_comb begin
    imem_req        = (state == S_REQ) && (fifo_count < 3'(FIFO_DEPTH)) && !redirect_valid;
    push            = (state == S_WAIT) && imem_ack && !redirect_valid;
    out_valid       = (fifo_count != '0) && !redirect_valid;
    pop             = out_valid && out_ready;
    redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
  end

  assign imem_addr            = fetch_pc;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Fetch FSM and fetch_pc. A redirect during an outstanding access parks in
  // S_DRAIN so the stale response is swallowed before the next request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      fetch_pc <= {RESET_PC[XLEN-1:2], 2'b00};
    end else begin
      case (state)
        S_IDLE: begin
          if (redirect_valid) fetch_pc <= redirect_target;
          state <= S_REQ;
        end
        S_REQ: begin
          if (redirect_valid) fetch_pc <= redirect_target;
          else if (imem_req) state <= S_WAIT;
        end
        S_WAIT: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_target;
            state    <= imem_ack ? S_REQ : S_DRAIN;
          end else if (imem_ack) begin
            fetch_pc <= fetch_pc + 64'd4;
            state    <= S_REQ;
          end
        end
        S_DRAIN: begin
          if (redirect_valid) fetch_pc <= redirect_target;
          else if (imem_ack) state <= S_REQ;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (push),
    .push_pc    (fetch_pc),
    .push_instr (imem_rdata),
    .pop        (pop),
    .count      (fifo_count),
    .head_pc    (out_pc),
    .head_instr (out_instr)
  );

endmodule
